// File: rtl/score_row_buffer.sv
// score_row_buffer: double-banked score row memory with boundary-init sequencer
// Holds two banks of N+1 signed W-bit scores. The "current" bank (bank_sel)
// takes writes and the "previous" bank (~bank_sel) serves registered reads.
// A one-cycle init pulse fills the previous bank with j*GAP, saturated to the
// W-bit signed range, for j = 0..N.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   init, swap             start boundary fill / exchange bank roles
//   we, addr_din, din      write into the current bank
//   en_dout, addr_dout     read from the previous bank
//   dout, dout_valid       registered read data, valid one cycle after a read
//   busy                   init sequencer running
//   bank_sel               index of the current bank
//   max_score, max_addr    running maximum of accepted writes
// Build option: define SCORE_ROW_BUFFER_MAX_EN to include the maximum tracker;
// without it max_score and max_addr are tied to 0.
module score_row_buffer #(
  parameter int N = 128,
  parameter int W = 9,
  parameter int GAP = -2,
  localparam int AW = $clog2(N+1)+1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                swap,
  input  logic                we,
  input  logic [AW-1:0]       addr_din,
  input  logic signed [W-1:0] din,
  input  logic                en_dout,
  input  logic [AW-1:0]       addr_dout,
  output logic signed [W-1:0] dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                bank_sel,
  output logic signed [W-1:0] max_score,
  output logic [AW-1:0]       max_addr
);
  localparam int IW = $clog2(N+1);
  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [AW-1:0] j;
  logic tgt;
  logic wr_ok, rd_ok;
  logic m_we, m_bank;
  logic [AW-1:0] m_addr;
  logic signed [W-1:0] m_data, fill_val;
  int prod;
  logic [W-1:0] mem [2][N+1];
  assign wr_ok = we && !busy && (addr_din <= AW'(N));
  assign rd_ok = en_dout && !busy && (addr_dout <= AW'(N));
  always_comb begin
    prod = int'(j) * GAP;
    fill_val = prod > MAXV ? W'(MAXV) : prod < MINV ? W'(MINV) : W'(prod);
  end
  // The sequencer owns the memory port while busy; user writes are blocked then.
  assign m_we = busy || wr_ok;
  assign m_bank = busy ? tgt : bank_sel;
  assign m_addr = busy ? j : addr_din;
  assign m_data = busy ? fill_val : din;
  always_ff @(posedge clk) begin
    if (m_we) mem[m_bank][m_addr[IW-1:0]] <= m_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      if (rd_ok) dout <= mem[~bank_sel][addr_dout[IW-1:0]];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      j <= '0;
      tgt <= 1'b0;
      bank_sel <= 1'b0;
    end else if (state == IDLE) begin
      if (init) begin
        state <= FILL;
        busy <= 1'b1;
        j <= '0;
        tgt <= ~bank_sel;
      end else if (swap) begin
        bank_sel <= ~bank_sel;
      end
    end else begin
      if (j == AW'(N)) begin
        state <= IDLE;
        busy <= 1'b0;
      end
      j <= j + 1'b1;
    end
  end
`ifdef SCORE_ROW_BUFFER_MAX_EN
  // A bank swap or a new init starts a new row, so the tracker restarts and
  // ignores any write landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_score <= W'(MINV);
      max_addr <= '0;
    end else if (!busy && (init || swap)) begin
      max_score <= W'(MINV);
      max_addr <= '0;
    end else if (wr_ok && din > max_score) begin
      max_score <= din;
      max_addr <= addr_din;
    end
  end
`else
  assign max_score = '0;
  assign max_addr = '0;
`endif
endmodule

// File: tb/tb_score_row_buffer.sv
module tb_score_row_buffer;
  localparam int N = 128;
  localparam int W = 9;
  localparam int AW = 9;
`ifdef SCORE_ROW_BUFFER_MAX_EN
  localparam int MAX_RST = -256;
`else
  localparam int MAX_RST = 0;
`endif
  logic clk = 1'b0;
  logic rst, init, swap, we, en_dout;
  logic [AW-1:0] addr_din, addr_dout, max_addr;
  logic signed [W-1:0] din, dout, max_score;
  logic dout_valid, busy, bank_sel;
  int total = 0;
  int bad = 0;
  int q[$];
  int cnt;
  score_row_buffer #(.N(N), .W(W), .GAP(-2)) dut (
    .clk(clk), .rst(rst), .init(init), .swap(swap), .we(we),
    .addr_din(addr_din), .din(din), .en_dout(en_dout), .addr_dout(addr_dout),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .bank_sel(bank_sel),
    .max_score(max_score), .max_addr(max_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  // Monitor: every valid read result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected got=%0d want=no_read", dout);
      end else begin
        chk("rd_data", int'(dout), q.pop_front());
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input int d);
    we = 1'b1; addr_din = AW'(a); din = W'(d);
    step();
    we = 1'b0;
  endtask
  task automatic rd(input int a, input int e);
    en_dout = 1'b1; addr_dout = AW'(a);
    if (a <= N) q.push_back(e);
    step();
    en_dout = 1'b0;
  endtask
  task automatic do_swap();
    swap = 1'b1;
    step();
    swap = 1'b0;
  endtask
  // Runs one init sequence and counts the cycles busy is seen high; with poke
  // set, illegal writes/init/swap are thrown at the sequencer while it runs.
  task automatic run_fill(output int c, input bit poke);
    init = 1'b1;
    step();
    init = 1'b0;
    c = 0;
    while (busy && c < 300) begin
      c++;
      if (poke && c == 10) begin we = 1'b1; addr_din = 7; din = 9; end
      if (poke && (c == 20 || c == 129)) init = 1'b1;
      if (poke && c == 50) swap = 1'b1;
      step();
      we = 1'b0; init = 1'b0; swap = 1'b0;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; init = 0; swap = 0; we = 0; en_dout = 0;
    addr_din = '0; addr_dout = '0; din = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_max_score", max_score, MAX_RST);
    chk("rst_max_addr", max_addr, 0);
    rst = 1'b0;
    step();
    run_fill(cnt, 1'b0);
    chk("fill_cycles", cnt, 129);
    rd(0, 0); rd(5, -10); rd(128, -256);
    step();
    chk("fill_bank_sel", bank_sel, 0);
    wr(0, 1); wr(1, 5);
    do_swap();
    chk("swap_bank_sel", bank_sel, 1);
    rd(0, 1); rd(1, 5);
    step();
    run_fill(cnt, 1'b1);
    chk("busy_fill_cycles", cnt, 129);
    chk("busy_swap_ignored", bank_sel, 1);
    step(); step();
    chk("no_restart", busy, 0);
    rd(7, -14); rd(0, 0);
    step();
    do_swap();
    rd(7, -14);
    step();
    chk("oor_pre_dout", dout, -14);
    wr(129, 33);
    rd(129, 0);
    step();
    chk("oor_dout_held", dout, -14);
    chk("oor_dout_valid", dout_valid, 0);
    do_swap();
    rd(1, -2);
    step();
    chk("pre_rst_bank_sel", bank_sel, 1);
    init = 1'b1; swap = 1'b1;
    step();
    init = 1'b0; swap = 1'b0;
    chk("init_wins_bank_sel", bank_sel, 1);
    chk("init_wins_busy", busy, 1);
    repeat (39) step();
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_bank_sel", bank_sel, 0);
    chk("async_rst_dout", dout, 0);
    chk("async_rst_dout_valid", dout_valid, 0);
    step();
    rst = 1'b0;
    step();
    chk("after_rst_busy", busy, 0);
    wr(2, 3); wr(9, 7); wr(11, 7);
`ifdef SCORE_ROW_BUFFER_MAX_EN
    chk("max_score", max_score, 7);
    chk("max_addr", max_addr, 9);
    do_swap();
    chk("max_swap_score", max_score, -256);
    chk("max_swap_addr", max_addr, 0);
`else
    chk("max_score_tied", max_score, 0);
    chk("max_addr_tied", max_addr, 0);
`endif
    step();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
